rom_loader: RTL

- Parametrised ROM download router between the HPS ioctl stream and up to NUM_REGIONS on-chip ROM/RAM targets.
- Decodes each downloaded byte by absolute address into a region and re-bases the address to that region.
- Delivers each byte through a one-entry buffer with a per-region ready handshake, and back-pressures the HPS via ioctl_wait.
- Holds the game core in reset during the download and for a programmable tail afterwards; reports byte count, checksum and error status.

---
 rtl/rom_loader_pkg.sv | 46 ++++
 rtl/rom_loader_decode.sv | 51 +++++
 rtl/rom_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM download router.
package rom_loader_pkg;

    localparam int unsigned MAX_REGIONS = 8;
    localparam int unsigned MAX_AW      = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StHold
    } state_e;

    // Pull field i (aw bits wide) out of a zero-extended packed parameter vector.
    function automatic logic [MAX_AW-1:0] region_field(
        input logic [MAX_REGIONS*MAX_AW-1:0] vec,
        input int unsigned                   aw,
        input int unsigned                   i
    );
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < MAX_AW; b++) begin
            if (b < aw && (i * aw + b) < MAX_REGIONS * MAX_AW) begin
                r[b] = vec[i*aw+b];
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_AW-1:0] region_base(
        input logic [MAX_REGIONS*MAX_AW-1:0] bases,
        input int unsigned                   aw,
        input int unsigned                   i
    );
        return region_field(bases, aw, i);
    endfunction

    function automatic logic [MAX_AW-1:0] region_size(
        input logic [MAX_REGIONS*MAX_AW-1:0] sizes,
        input int unsigned                   aw,
        input int unsigned                   i
    );
        return region_field(sizes, aw, i);
    endfunction

endpackage

// File: rtl/rom_loader_decode.sv
// Address-to-region priority decoder: lowest matching region wins.
module rom_loader_decode
    import rom_loader_pkg::*;
#(
    parameter int unsigned                     NUM_REGIONS = 4,
    parameter int unsigned                     ADDR_W      = 25,
    parameter int unsigned                     REGION_AW   = 14,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_SIZE = '0
) (
    input  logic [ADDR_W-1:0]      addr_i,
    output logic                   hit_o,
    output logic [NUM_REGIONS-1:0] sel_o,
    output logic [REGION_AW-1:0]   offset_o
);

    localparam logic [MAX_REGIONS*MAX_AW-1:0] BaseVec = (MAX_REGIONS*MAX_AW)'(REGION_BASE);
    localparam logic [MAX_REGIONS*MAX_AW-1:0] SizeVec = (MAX_REGIONS*MAX_AW)'(REGION_SIZE);

    logic [NUM_REGIONS-1:0] in_range;
    logic [ADDR_W-1:0]      base_arr [NUM_REGIONS];
    logic [ADDR_W-1:0]      diff;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [MAX_AW-1:0] Base = region_base(BaseVec, ADDR_W, g);
        localparam logic [MAX_AW-1:0] Size = region_size(SizeVec, ADDR_W, g);
        // One extra bit so base + size never wraps at the top of the address space.
        localparam logic [ADDR_W:0]   Lo   = (ADDR_W+1)'(Base);
        localparam logic [ADDR_W:0]   Hi   = Lo + (ADDR_W+1)'(Size);

        assign in_range[g] = ({1'b0, addr_i} >= Lo) && ({1'b0, addr_i} < Hi);
        assign base_arr[g] = Base[ADDR_W-1:0];
    end

    always_comb begin
        hit_o    = 1'b0;
        sel_o    = '0;
        offset_o = '0;
        diff     = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (in_range[i]) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                diff     = addr_i - base_arr[i];
                offset_o = diff[REGION_AW-1:0];
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Routes HPS ioctl download bytes into per-region ROM/RAM targets and holds the core in reset.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned                     INDEX       = 0,
    parameter int unsigned                     NUM_REGIONS = 4,
    parameter int unsigned                     ADDR_W      = 25,
    parameter int unsigned                     REGION_AW   = 14,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_SIZE = {NUM_REGIONS{ADDR_W'(1 << REGION_AW)}},
    parameter int unsigned                     RESET_HOLD  = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [REGION_AW-1:0]   dn_addr,
    output logic [7:0]             dn_data,
    output logic [NUM_REGIONS-1:0] dn_wr,
    input  logic [NUM_REGIONS-1:0] dn_ready,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W-1:0]      byte_count,
    output logic [7:0]             checksum
);

    localparam int unsigned     HoldW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

    state_e                 state_q;
    logic [NUM_REGIONS-1:0] dn_wr_q;
    logic [REGION_AW-1:0]   dn_addr_q;
    logic [7:0]             dn_data_q;
    logic [ADDR_W-1:0]      byte_count_q;
    logic [7:0]             checksum_q;
    logic                   error_q;
    logic                   done_q;
    logic [HoldW-1:0]       hold_cnt_q;

    logic                   active;
    logic                   buf_full;
    logic                   buf_free;
    logic                   accept;
    logic                   overrun;
    logic                   dec_hit;
    logic [NUM_REGIONS-1:0] dec_sel;
    logic [REGION_AW-1:0]   dec_offset;

    rom_loader_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_AW   (REGION_AW),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr_i   (ioctl_addr),
        .hit_o    (dec_hit),
        .sel_o    (dec_sel),
        .offset_o (dec_offset)
    );

    assign active   = ioctl_download && (ioctl_index == 8'(INDEX));
    assign buf_full = |dn_wr_q;
    assign buf_free = |(dn_wr_q & dn_ready);
    // A slot freeing this cycle can take a new byte at once (back-to-back write).
    assign accept   = ioctl_wr && active && (state_q == StLoad) && (!buf_full || buf_free);
    assign overrun  = ioctl_wr && active && (state_q == StLoad) && buf_full && !buf_free;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            dn_wr_q      <= '0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (buf_free) begin
                dn_wr_q <= '0;
            end
            if (accept) begin
                byte_count_q <= byte_count_q + ADDR_W'(1);
                checksum_q   <= checksum_q + ioctl_dout;
                if (dec_hit) begin
                    dn_wr_q   <= dec_sel;
                    dn_addr_q <= dec_offset;
                    dn_data_q <= ioctl_dout;
                end else begin
                    error_q <= 1'b1;
                end
            end
            if (overrun) begin
                error_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (active) begin
                        state_q      <= StLoad;
                        byte_count_q <= '0;
                        checksum_q   <= '0;
                        error_q      <= 1'b0;
                    end
                end
                StLoad: begin
                    if (!active) begin
                        if (buf_full && !buf_free) begin
                            state_q <= StDrain;
                        end else begin
                            state_q    <= StHold;
                            hold_cnt_q <= HoldLast;
                        end
                    end
                end
                StDrain: begin
                    if (active) begin
                        state_q <= StLoad;
                    end else if (buf_free) begin
                        state_q    <= StHold;
                        hold_cnt_q <= HoldLast;
                    end
                end
                StHold: begin
                    if (active) begin
                        state_q      <= StLoad;
                        byte_count_q <= '0;
                        checksum_q   <= '0;
                        error_q      <= 1'b0;
                    end else if (hold_cnt_q == '0) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HoldW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ioctl_wait = buf_full && !buf_free;
    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign busy       = (state_q != StIdle);
    assign core_reset = reset || busy;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule
